// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
// SPI mode-0 NOR-flash responder answering READ (0x03), JEDEC ID (0x9F) and RDSR (0x05).
// The SPI pins are oversampled on clk. Read data comes from a byte port with one-cycle latency.
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_data
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_ID     = 3'd4,
        ST_STATUS = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    logic [2:0]            sclk_sync_q;
    logic [2:0]            cs_sync_q;
    logic [1:0]            mosi_sync_q;

    state_t                state_q,     state_d;
    logic [2:0]            bit_cnt_q,   bit_cnt_d;
    logic [1:0]            byte_cnt_q,  byte_cnt_d;
    logic [6:0]            shift_in_q,  shift_in_d;
    logic [22:0]           addr_q,      addr_d;
    logic [7:0]            shift_out_q, shift_out_d;
    logic [7:0]            prefetch_q,  prefetch_d;
    logic                  cap_q,       cap_d;
    logic                  load_q,      load_d;
    logic                  miso_q,      miso_d;
    logic                  miso_oe_q,   miso_oe_d;
    logic                  mem_rd_q,    mem_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;

    logic                  rise_s;
    logic                  fall_s;
    logic                  cs_assert_s;
    logic                  cs_deassert_s;
    logic                  mosi_s;
    logic [7:0]            rx_byte_s;
    logic [23:0]           addr_next_s;
    logic [7:0]            tx_byte_s;

    // Two-flop synchronisers plus a third stage for edge detection.
    // The cs_n chain resets to "selected" so a cs_n already low at reset release is not seen as an assert.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b000;
            mosi_sync_q <= 2'b00;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            cs_sync_q   <= {cs_sync_q[1:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
        end
    end

    assign rise_s        =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fall_s        = ~sclk_sync_q[1] &  sclk_sync_q[2];
    assign cs_assert_s   = ~cs_sync_q[1]   &  cs_sync_q[2];
    assign cs_deassert_s =  cs_sync_q[1]   & ~cs_sync_q[2];
    assign mosi_s        =  mosi_sync_q[1];
    assign rx_byte_s     = {shift_in_q, mosi_s};
    assign addr_next_s   = {addr_q, mosi_s};

    // Select the byte loaded into the output shifter at a byte boundary.
    always_comb begin
        tx_byte_s = 8'h00;
        case (state_q)
            ST_DATA: tx_byte_s = prefetch_q;
            ST_ID: begin
                case (byte_cnt_q)
                    2'd0:    tx_byte_s = JEDEC_ID[23:16];
                    2'd1:    tx_byte_s = JEDEC_ID[15:8];
                    2'd2:    tx_byte_s = JEDEC_ID[7:0];
                    default: tx_byte_s = 8'h00;
                endcase
            end
            default: tx_byte_s = 8'h00;
        endcase
    end

    // Next-state and output logic; chip-select deassert overrides every state.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shift_in_d  = shift_in_q;
        addr_d      = addr_q;
        shift_out_d = shift_out_q;
        prefetch_d  = cap_q ? mem_data : prefetch_q;
        cap_d       = mem_rd_q;
        load_d      = load_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;

        if (cs_deassert_s) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            load_d     = 1'b0;
            cap_d      = 1'b0;
            prefetch_d = prefetch_q;
            miso_d     = 1'b1;
            miso_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_assert_s) begin
                        state_d     = ST_CMD;
                        bit_cnt_d   = 3'd0;
                        byte_cnt_d  = 2'd0;
                        shift_in_d  = 7'd0;
                        addr_d      = 23'd0;
                        shift_out_d = 8'd0;
                        load_d      = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (rise_s) begin
                        shift_in_d = rx_byte_s[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = 2'd0;
                            case (rx_byte_s)
                                8'h03: state_d = ST_ADDR;
                                8'h9F: begin
                                    state_d = ST_ID;
                                    load_d  = 1'b1;
                                end
                                8'h05: begin
                                    state_d = ST_STATUS;
                                    load_d  = 1'b1;
                                end
                                default: state_d = ST_IGNORE;
                            endcase
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_ADDR: begin
                    if (rise_s) begin
                        addr_d    = addr_next_s[22:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && byte_cnt_q == 2'd2) begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr_next_s[ADDR_WIDTH-1:0];
                            byte_cnt_d = 2'd0;
                            load_d     = 1'b1;
                            state_d    = ST_DATA;
                        end else if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end else begin
                            byte_cnt_d = byte_cnt_q;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_DATA, ST_ID, ST_STATUS: begin
                    if (rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            load_d = 1'b1;
                        end else begin
                            load_d = load_q;
                        end
                    end else if (fall_s) begin
                        miso_oe_d = 1'b1;
                        if (load_q) begin
                            // Byte boundary: present the next byte and refill the prefetch.
                            load_d      = 1'b0;
                            miso_d      = tx_byte_s[7];
                            shift_out_d = {tx_byte_s[6:0], 1'b0};
                            if (state_q == ST_DATA) begin
                                mem_rd_d   = 1'b1;
                                mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                            end else if (state_q == ST_ID && byte_cnt_q != 2'd3) begin
                                byte_cnt_d = byte_cnt_q + 2'd1;
                            end else begin
                                byte_cnt_d = byte_cnt_q;
                            end
                        end else begin
                            miso_d      = shift_out_q[7];
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            byte_cnt_q  <= 2'd0;
            shift_in_q  <= 7'd0;
            addr_q      <= 23'd0;
            shift_out_q <= 8'd0;
            prefetch_q  <= 8'd0;
            cap_q       <= 1'b0;
            load_q      <= 1'b0;
            miso_q      <= 1'b1;
            miso_oe_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_in_q  <= shift_in_d;
            addr_q      <= addr_d;
            shift_out_q <= shift_out_d;
            prefetch_q  <= prefetch_d;
            cap_q       <= cap_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = miso_oe_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
// Bench for spi_flash_responder: an SPI mode-0 initiator drives directed and random transactions,
// and a reference model gives the expected miso bytes and memory read addresses.
module tb_spi_flash_responder;

    localparam logic [23:0] JID = 24'hEF4018;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;

    int          n_checks = 0;
    int          n_errors = 0;
    int          half_ns = 60;
    int          oe_hi_cnt = 0;
    int          oe_lo_cnt = 0;
    int          consec_cnt = 0;
    logic        mem_rd_prev = 1'b0;
    logic [7:0]  mem_xor = 8'h00;
    logic [23:0] rd_q[$];

    spi_flash_responder #(.ADDR_WIDTH(24), .JEDEC_ID(JID)) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory: content is the low address byte XOR a per-transaction salt.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem_addr[7:0] ^ mem_xor;
    end

    // Record read strobes and flag back-to-back strobes.
    always @(negedge clk) begin
        if (!reset && mem_rd) begin
            rd_q.push_back(mem_addr);
            if (mem_rd_prev) consec_cnt++;
        end
        mem_rd_prev = mem_rd;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx MSB-first; miso is sampled just before each rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit end_cs,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #(half_ns);
            rx = {rx[6:0], miso};
            if (miso_oe) oe_hi_cnt++; else oe_lo_cnt++;
            sclk = 1'b1;
            #(half_ns);
            sclk = 1'b0;
            if (end_cs && i == nbits - 1) cs_n = 1'b1;
        end
    endtask

    task automatic after_cs(input string tag);
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, "_oe_off"}, 32'(miso_oe), 32'd0);
        #(150);
    endtask

    // One complete transaction checked against the reference model.
    task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] addr,
                           input int nbytes);
        logic [7:0]  rx;
        logic [7:0]  exp_b;
        logic [23:0] a;
        bit          valid;
        int          exp_rd;
        valid = (op == 8'h03) || (op == 8'h9F) || (op == 8'h05);
        rd_q.delete();
        cs_n = 1'b0;
        #(half_ns);
        spi_bits(op, 8, 1'b0, rx);
        if (op == 8'h03) begin
            spi_bits(addr[23:16], 8, 1'b0, rx);
            spi_bits(addr[15:8], 8, 1'b0, rx);
            spi_bits(addr[7:0], 8, 1'b0, rx);
        end
        oe_hi_cnt = 0;
        oe_lo_cnt = 0;
        for (int k = 0; k < nbytes; k++) begin
            spi_bits(8'($urandom), 8, (k == nbytes - 1), rx);
            if (op == 8'h03) begin
                a     = addr + 24'(k);
                exp_b = a[7:0] ^ mem_xor;
            end else if (op == 8'h9F) begin
                exp_b = (k < 3) ? 8'(JID >> (8 * (2 - k))) : 8'h00;
            end else begin
                exp_b = 8'h00;
            end
            if (valid) check_val($sformatf("%s_byte%0d", tag, k), 32'(rx), 32'(exp_b));
        end
        if (valid) check_val({tag, "_oe_low_samples"}, 32'(oe_lo_cnt), 32'd0);
        else       check_val({tag, "_oe_high_samples"}, 32'(oe_hi_cnt), 32'd0);
        after_cs(tag);
        exp_rd = (op == 8'h03) ? nbytes + 1 : 0;
        check_val({tag, "_rd_count"}, 32'(rd_q.size()), 32'(exp_rd));
        for (int i = 0; i < exp_rd && i < rd_q.size(); i++) begin
            a = addr + 24'(i);
            check_val($sformatf("%s_rd_addr%0d", tag, i), 32'(rd_q[i]), 32'(a));
        end
    endtask

    initial begin
        logic [7:0]  rx;
        logic [7:0]  op;
        logic [23:0] addr;

        reset = 1'b1;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_miso", 32'(miso), 32'd1);
        check_val("rst_oe", 32'(miso_oe), 32'd0);
        check_val("rst_rd", 32'(mem_rd), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        run_txn("read10", 8'h03, 24'h000010, 4);
        run_txn("wrap", 8'h03, 24'hFFFFFE, 3);
        run_txn("jedec", 8'h9F, 24'h0, 4);
        run_txn("unknown", 8'hAB, 24'h0, 2);
        run_txn("rdsr", 8'h05, 24'h0, 1);

        // Abort after 12 address bits.
        rd_q.delete();
        oe_hi_cnt = 0;
        cs_n = 1'b0;
        #(half_ns);
        spi_bits(8'h03, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'h00, 4, 1'b1, rx);
        after_cs("abort");
        check_val("abort_rd_count", 32'(rd_q.size()), 32'd0);
        check_val("abort_oe_high", 32'(oe_hi_cnt), 32'd0);
        run_txn("post_abort", 8'h03, 24'h000020, 1);

        // Reset in the middle of the second data byte, then clocks with cs_n held low.
        cs_n = 1'b0;
        #(half_ns);
        spi_bits(8'h03, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'h40, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        check_val("mid_byte0", 32'(rx), 32'h40);
        spi_bits(8'h00, 3, 1'b0, rx);
        #(half_ns / 2);
        reset = 1'b1;
        #1;
        check_val("midrst_miso", 32'(miso), 32'd1);
        check_val("midrst_oe", 32'(miso_oe), 32'd0);
        check_val("midrst_rd", 32'(mem_rd), 32'd0);
        check_val("midrst_addr", 32'(mem_addr), 32'd0);
        #40;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        rd_q.delete();
        oe_hi_cnt = 0;
        spi_bits(8'h03, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        check_val("held_cs_oe_high", 32'(oe_hi_cnt), 32'd0);
        check_val("held_cs_rd_count", 32'(rd_q.size()), 32'd0);
        #(half_ns);
        cs_n = 1'b1;
        #(200);
        run_txn("post_reset", 8'h03, 24'h000005, 1);

        // Randomised transactions.
        for (int t = 0; t < 16; t++) begin
            half_ns = $urandom_range(55, 80);
            mem_xor = 8'($urandom);
            case ($urandom_range(0, 3))
                0: op = 8'h03;
                1: op = 8'h9F;
                2: op = 8'h05;
                default: begin
                    do op = 8'($urandom); while (op == 8'h03 || op == 8'h9F || op == 8'h05);
                end
            endcase
            if ($urandom_range(0, 3) == 0) addr = 24'hFFFFFF - 24'($urandom_range(0, 3));
            else                           addr = 24'($urandom);
            run_txn($sformatf("rnd%0d", t), op, addr, $urandom_range(1, 4));
        end

        check_val("rd_back_to_back", 32'(consec_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
